// File: rtl/ex_operand_stage_pkg.sv
// rtl/ex_operand_stage_pkg.sv - shared cpu package: widths, ALU opcodes, ID/EX bubble value
//
// Purpose : constants and types shared by the EX operand stage and its forwarding muxes.
// Contents: CPU_DATA_W / CPU_RIDX_W datapath and register-index widths,
//           alu_op_t opcode encoding (0-12), id_ex_ctrl_t control half of the
//           ID/EX register and ID_EX_CTRL_BUBBLE, its bubble value.
package ex_operand_stage_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_RIDX_W = 2;
    localparam int CPU_OP_W   = 4;

    typedef enum logic [CPU_OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_LUI   = 4'd10,
        OP_PASSA = 4'd11,
        OP_PASSB = 4'd12
    } alu_op_t;

    // Control half of the ID/EX register; data fields live beside it in the
    // stage so their widths can follow the stage parameters.
    typedef struct packed {
        logic    valid;
        logic    reg_write;
        logic    mem_read;
        logic    use_imm;
        logic    uses_rs1;
        logic    uses_rs2;
        alu_op_t op;
    } id_ex_ctrl_t;

    // A bubble never writes, never reads memory and never forwards. Data
    // fields of a bubble are all zero.
    localparam id_ex_ctrl_t ID_EX_CTRL_BUBBLE = '{
        valid:     1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        use_imm:   1'b0,
        uses_rs1:  1'b0,
        uses_rs2:  1'b0,
        op:        OP_ADD
    };

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// rtl/ex_operand_stage_fwd_mux.sv - one-operand MEM/WB forwarding mux
//
// Purpose : select the freshest value of one source register for the ALU.
// Ports   : enable        - instruction really reads this source
//           rs, reg_data  - registered source index and register-file data
//           mem_*         - MEM stage writeback candidate (highest priority)
//           wb_*          - WB stage writeback candidate
//           operand       - selected operand value
module fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int RIDX_W = CPU_RIDX_W
) (
    input  logic              enable,
    input  logic [RIDX_W-1:0] rs,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [RIDX_W-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] operand
);

    // MEM is younger than WB, so its value wins when both target rs.
    always_comb begin
        operand = reg_data;
        if (enable) begin
            if (mem_reg_write && (mem_rd == rs)) begin
                operand = mem_result;
            end else if (wb_reg_write && (wb_rd == rs)) begin
                operand = wb_result;
            end
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with load-use stall and operand forwarding
//
// Purpose : hold the instruction entering EX, detect load-use hazards and
//           forward MEM/WB results onto the ALU operands.
// Ports   : clk, reset (sync, active-high)
//           id_*           - decoded instruction from the decode stage
//           flush          - squash the instruction entering EX
//           mem_*, wb_*    - forwarding sources
//           alu_a, alu_b, alu_op - ALU operands and opcode
//           ex_valid, ex_rd, ex_reg_write, ex_mem_read - EX-stage control
//           stall_req      - load-use hazard; fetch/decode hold this cycle
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int RIDX_W = CPU_RIDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [3:0]        id_op,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [RIDX_W-1:0] id_rs1,
    input  logic [RIDX_W-1:0] id_rs2,
    input  logic [RIDX_W-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic [RIDX_W-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [RIDX_W-1:0] ex_rd,
    output logic              stall_req
);

    id_ex_ctrl_t       ctrl_q;
    logic [DATA_W-1:0] rs1_data_q;
    logic [DATA_W-1:0] rs2_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [RIDX_W-1:0] rs1_q;
    logic [RIDX_W-1:0] rs2_q;
    logic [RIDX_W-1:0] rd_q;

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // A load in EX cannot forward until MEM, so a consumer in decode must
    // wait one cycle. The bubble this inserts has ex_valid=0, which drops
    // stall_req on the next cycle, so the stall never lasts more than one.
    always_comb begin
        stall_req = ctrl_q.valid && ctrl_q.mem_read && id_valid &&
                    ((id_uses_rs1 && (id_rs1 == rd_q)) ||
                     (id_uses_rs2 && (id_rs2 == rd_q)));
    end

    // reset > flush > stall_req > load. All but the last load a bubble, so
    // a flush coinciding with a stall still produces exactly one bubble.
    always_ff @(posedge clk) begin
        if (reset || flush || stall_req || !id_valid) begin
            ctrl_q     <= ID_EX_CTRL_BUBBLE;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else begin
            ctrl_q.valid     <= 1'b1;
            ctrl_q.reg_write <= id_reg_write;
            ctrl_q.mem_read  <= id_mem_read;
            ctrl_q.use_imm   <= id_use_imm;
            ctrl_q.uses_rs1  <= id_uses_rs1;
            ctrl_q.uses_rs2  <= id_uses_rs2;
            ctrl_q.op        <= alu_op_t'(id_op);
            rs1_data_q       <= id_rs1_data;
            rs2_data_q       <= id_rs2_data;
            imm_q            <= id_imm;
            rs1_q            <= id_rs1;
            rs2_q            <= id_rs2;
            rd_q             <= id_rd;
        end
    end

    fwd_mux #(
        .DATA_W (DATA_W),
        .RIDX_W (RIDX_W)
    ) u_fwd_a (
        .enable        (ctrl_q.uses_rs1),
        .rs            (rs1_q),
        .reg_data      (rs1_data_q),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .operand       (fwd_a)
    );

    fwd_mux #(
        .DATA_W (DATA_W),
        .RIDX_W (RIDX_W)
    ) u_fwd_b (
        .enable        (ctrl_q.uses_rs2),
        .rs            (rs2_q),
        .reg_data      (rs2_data_q),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .operand       (fwd_b)
    );

    // Bubbles present zero operands regardless of what MEM/WB are writing.
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        if (ctrl_q.valid) begin
            alu_a = fwd_a;
            alu_b = ctrl_q.use_imm ? imm_q : fwd_b;
        end
    end

    assign alu_op       = ctrl_q.op;
    assign ex_valid     = ctrl_q.valid;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_rd        = rd_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [3:0]  id_op;
    logic [15:0] id_rs1_data;
    logic [15:0] id_rs2_data;
    logic [15:0] id_imm;
    logic        id_use_imm;
    logic [1:0]  id_rs1;
    logic [1:0]  id_rs2;
    logic [1:0]  id_rd;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;
    logic [1:0]  mem_rd;
    logic        mem_reg_write;
    logic [15:0] mem_result;
    logic [1:0]  wb_rd;
    logic        wb_reg_write;
    logic [15:0] wb_result;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [1:0]  ex_rd;
    logic        stall_req;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_op         (id_op),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_use_imm    (id_use_imm),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .flush         (flush),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .stall_req     (stall_req)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_idle();
        id_valid     = 1'b0;
        id_op        = 4'd0;
        id_rs1_data  = 16'h0000;
        id_rs2_data  = 16'h0000;
        id_imm       = 16'h0000;
        id_use_imm   = 1'b0;
        id_rs1       = 2'd0;
        id_rs2       = 2'd0;
        id_rd        = 2'd0;
        id_uses_rs1  = 1'b0;
        id_uses_rs2  = 1'b0;
        id_reg_write = 1'b0;
        id_mem_read  = 1'b0;
    endtask

    task automatic fwd_idle();
        mem_rd        = 2'd0;
        mem_reg_write = 1'b0;
        mem_result    = 16'h0000;
        wb_rd         = 2'd0;
        wb_reg_write  = 1'b0;
        wb_result     = 16'h0000;
    endtask

    task automatic id_instr(input logic [3:0] op, input logic [1:0] rs1, input logic u1,
                            input logic [15:0] d1, input logic [1:0] rs2, input logic u2,
                            input logic [15:0] d2, input logic [1:0] rd, input logic mr);
        id_valid     = 1'b1;
        id_op        = op;
        id_rs1       = rs1;
        id_uses_rs1  = u1;
        id_rs1_data  = d1;
        id_rs2       = rs2;
        id_uses_rs2  = u2;
        id_rs2_data  = d2;
        id_rd        = rd;
        id_reg_write = 1'b1;
        id_mem_read  = mr;
        id_use_imm   = 1'b0;
        id_imm       = 16'h0000;
    endtask

    initial begin
        // Reset held two cycles with a valid instruction presented.
        reset = 1'b1;
        flush = 1'b0;
        fwd_idle();
        id_instr(4'd5, 2'd1, 1'b1, 16'h1234, 2'd2, 1'b1, 16'h5678, 2'd3, 1'b0);
        tick();
        tick();
        chk("reset_ex_valid", ex_valid, 0);
        chk("reset_alu_op", alu_op, 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_alu_b", alu_b, 0);
        chk("reset_stall", stall_req, 0);

        // Plain ADD r3 = r1 + r2.
        reset = 1'b0;
        id_instr(4'd0, 2'd1, 1'b1, 16'h0003, 2'd2, 1'b1, 16'h0004, 2'd3, 1'b0);
        tick();
        chk("add_alu_a", alu_a, 16'h0003);
        chk("add_alu_b", alu_b, 16'h0004);
        chk("add_alu_op", alu_op, 0);
        chk("add_ex_valid", ex_valid, 1);
        chk("add_ex_rd", ex_rd, 3);
        chk("add_ex_reg_write", ex_reg_write, 1);
        chk("add_stall", stall_req, 0);

        // Forwarding priority on operand A, then B, EX instruction unchanged.
        id_idle();
        mem_rd = 2'd1; mem_reg_write = 1'b1; mem_result = 16'h1111;
        wb_rd  = 2'd1; wb_reg_write  = 1'b1; wb_result  = 16'h2222;
        #1;
        chk("fwd_mem_over_wb", alu_a, 16'h1111);
        mem_reg_write = 1'b0;
        #1;
        chk("fwd_wb", alu_a, 16'h2222);
        wb_rd = 2'd2; wb_result = 16'hBEEF;
        #1;
        chk("fwd_wb_b", alu_b, 16'hBEEF);
        chk("fwd_a_none", alu_a, 16'h0003);
        fwd_idle();

        // id_valid=0 loaded last edge -> bubble; forwarding must not leak.
        tick();
        mem_rd = 2'd0; mem_reg_write = 1'b1; mem_result = 16'h9999;
        #1;
        chk("idle_ex_valid", ex_valid, 0);
        chk("idle_alu_a", alu_a, 0);
        fwd_idle();

        // uses_rs1=0: matching MEM write must not forward.
        id_instr(4'd11, 2'd1, 1'b0, 16'h0055, 2'd2, 1'b1, 16'h0006, 2'd0, 1'b0);
        tick();
        mem_rd = 2'd1; mem_reg_write = 1'b1; mem_result = 16'h1111;
        #1;
        chk("nouse_alu_a", alu_a, 16'h0055);
        chk("nouse_alu_op", alu_op, 11);
        fwd_idle();

        // Immediate bypasses forwarding on B.
        id_instr(4'd0, 2'd1, 1'b1, 16'h0001, 2'd2, 1'b1, 16'h0004, 2'd3, 1'b0);
        id_use_imm = 1'b1;
        id_imm     = 16'h00FF;
        tick();
        wb_rd = 2'd2; wb_reg_write = 1'b1; wb_result = 16'hBEEF;
        #1;
        chk("imm_alu_b", alu_b, 16'h00FF);
        fwd_idle();

        // Load-use: load to r2 then a consumer of r2.
        id_instr(4'd0, 2'd0, 1'b1, 16'h0010, 2'd0, 1'b0, 16'h0000, 2'd2, 1'b1);
        tick();
        chk("ld_ex_mem_read", ex_mem_read, 1);
        id_instr(4'd1, 2'd2, 1'b1, 16'h0007, 2'd3, 1'b1, 16'h0002, 2'd1, 1'b0);
        #1;
        chk("lu_stall", stall_req, 1);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_reg_write", ex_reg_write, 0);
        chk("lu_bubble_alu_a", alu_a, 0);
        chk("lu_bubble_stall", stall_req, 0);
        tick();
        chk("lu_dep_valid", ex_valid, 1);
        chk("lu_dep_op", alu_op, 1);
        chk("lu_dep_rd", ex_rd, 1);
        chk("lu_dep_alu_a", alu_a, 16'h0007);
        chk("lu_dep_stall", stall_req, 0);

        // Flush coinciding with stall: one bubble, the consumer never enters.
        id_instr(4'd0, 2'd0, 1'b1, 16'h0010, 2'd0, 1'b0, 16'h0000, 2'd2, 1'b1);
        tick();
        id_instr(4'd2, 2'd2, 1'b1, 16'h0007, 2'd3, 1'b0, 16'h0000, 2'd1, 1'b0);
        flush = 1'b1;
        #1;
        chk("fs_stall", stall_req, 1);
        tick();
        flush = 1'b0;
        id_idle();
        #1;
        chk("fs_bubble_valid", ex_valid, 0);
        chk("fs_bubble_reg_write", ex_reg_write, 0);
        chk("fs_bubble_stall", stall_req, 0);
        tick();
        chk("fs_no_dup_valid", ex_valid, 0);
        chk("fs_no_dup_op", alu_op, 0);

        // Plain flush of a valid, non-hazard instruction.
        id_instr(4'd3, 2'd1, 1'b1, 16'h00AA, 2'd2, 1'b1, 16'h0055, 2'd3, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", ex_valid, 0);
        chk("flush_alu_b", alu_b, 0);

        // Reset mid-hazard discards the consumer; decode re-presents it.
        id_instr(4'd0, 2'd0, 1'b1, 16'h0010, 2'd0, 1'b0, 16'h0000, 2'd2, 1'b1);
        tick();
        id_instr(4'd4, 2'd3, 1'b0, 16'h000F, 2'd2, 1'b1, 16'h00F0, 2'd1, 1'b0);
        #1;
        chk("rh_stall", stall_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rh_valid", ex_valid, 0);
        chk("rh_stall_after", stall_req, 0);
        tick();
        chk("rh_replay_valid", ex_valid, 1);
        chk("rh_replay_op", alu_op, 4);
        chk("rh_replay_alu_b", alu_b, 16'h00F0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
